// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - shared constants for the Morse symbol decoder
package morse_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_EMIT    = 2'd2;

    localparam logic [7:0] ASCII_SPACE   = 8'h20;
    localparam logic [7:0] ASCII_UNKNOWN = 8'h3F;

    localparam logic DOT  = 1'b0;
    localparam logic DASH = 1'b1;

    localparam int MAX_SYMBOLS_DEF = 5;

endpackage

// File: rtl/morse_lut.sv
// rtl/morse_lut.sv - {length, pattern} to ASCII table for A-Z and 0-9
// Pattern is right-aligned with the first symbol in the highest used bit; dot=0, dash=1.
module morse_lut (
    input  logic [2:0] len_i,
    input  logic [4:0] pattern_i,
    output logic       hit_o,
    output logic [7:0] ascii_o
);

    always_comb begin
        hit_o   = 1'b1;
        ascii_o = 8'h00;
        case ({len_i, pattern_i})
            8'b001_00000: ascii_o = 8'h45; // E
            8'b001_00001: ascii_o = 8'h54; // T
            8'b010_00000: ascii_o = 8'h49; // I
            8'b010_00001: ascii_o = 8'h41; // A
            8'b010_00010: ascii_o = 8'h4E; // N
            8'b010_00011: ascii_o = 8'h4D; // M
            8'b011_00000: ascii_o = 8'h53; // S
            8'b011_00001: ascii_o = 8'h55; // U
            8'b011_00010: ascii_o = 8'h52; // R
            8'b011_00011: ascii_o = 8'h57; // W
            8'b011_00100: ascii_o = 8'h44; // D
            8'b011_00101: ascii_o = 8'h4B; // K
            8'b011_00110: ascii_o = 8'h47; // G
            8'b011_00111: ascii_o = 8'h4F; // O
            8'b100_00000: ascii_o = 8'h48; // H
            8'b100_00001: ascii_o = 8'h56; // V
            8'b100_00010: ascii_o = 8'h46; // F
            8'b100_00100: ascii_o = 8'h4C; // L
            8'b100_00110: ascii_o = 8'h50; // P
            8'b100_00111: ascii_o = 8'h4A; // J
            8'b100_01000: ascii_o = 8'h42; // B
            8'b100_01001: ascii_o = 8'h58; // X
            8'b100_01010: ascii_o = 8'h43; // C
            8'b100_01011: ascii_o = 8'h59; // Y
            8'b100_01100: ascii_o = 8'h5A; // Z
            8'b100_01101: ascii_o = 8'h51; // Q
            8'b101_11111: ascii_o = 8'h30;
            8'b101_01111: ascii_o = 8'h31;
            8'b101_00111: ascii_o = 8'h32;
            8'b101_00011: ascii_o = 8'h33;
            8'b101_00001: ascii_o = 8'h34;
            8'b101_00000: ascii_o = 8'h35;
            8'b101_10000: ascii_o = 8'h36;
            8'b101_11000: ascii_o = 8'h37;
            8'b101_11100: ascii_o = 8'h38;
            8'b101_11110: ascii_o = 8'h39;
            default: begin
                hit_o   = 1'b0;
                ascii_o = 8'h00;
            end
        endcase
    end

endmodule

// File: rtl/morse_symbol_decoder.sv
// rtl/morse_symbol_decoder.sv - buffers dot/dash pulses and emits one ASCII character per commit
module morse_symbol_decoder
    import morse_pkg::*;
#(
    parameter int MAX_SYMBOLS = MAX_SYMBOLS_DEF,
    parameter int GAP_CYCLES  = 75_000_000,
    parameter int CNT_W       = 27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dot_pulse,
    input  logic       dash_pulse,
    input  logic       enter_pulse,
    output logic [7:0] char_data,
    output logic       char_valid,
    input  logic       char_ready,
    output logic [2:0] sym_count,
    output logic       overrun
);

    logic [1:0]             state_q, state_d;
    logic [MAX_SYMBOLS-1:0] pat_q, pat_d, app_pat;
    logic [2:0]             cnt_q, cnt_d, app_cnt;
    logic                   err_q, err_d, app_err;
    logic [CNT_W-1:0]       gap_q, gap_d, gap_inc;
    logic [7:0]             char_q, char_d;
    logic                   ovr_q, ovr_d;
    logic                   any_sym, both_sym, one_sym, full, commit_gap;
    logic                   lut_hit;
    logic [7:0]             lut_ascii;

    assign any_sym  = dot_pulse | dash_pulse;
    assign both_sym = dot_pulse & dash_pulse;
    assign one_sym  = dot_pulse ^ dash_pulse;
    assign full     = (cnt_q == 3'(MAX_SYMBOLS));
    assign gap_inc  = gap_q + 1'b1;

    // Buffer contents as they will be after this cycle's symbol, so a symbol
    // arriving with enter is included in the same commit.
    always_comb begin
        app_pat = pat_q;
        app_cnt = cnt_q;
        app_err = err_q;
        if (both_sym || (one_sym && full)) begin
            app_err = 1'b1;
        end else if (one_sym) begin
            app_pat = {pat_q[MAX_SYMBOLS-2:0], dash_pulse ? DASH : DOT};
            app_cnt = cnt_q + 3'd1;
        end
    end

    morse_lut u_lut (
        .len_i     (app_cnt),
        .pattern_i (5'(app_pat)),
        .hit_o     (lut_hit),
        .ascii_o   (lut_ascii)
    );

    assign commit_gap = (state_q == ST_COLLECT) && !any_sym && (GAP_CYCLES != 0)
                        && (gap_inc == CNT_W'(GAP_CYCLES));

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        gap_d   = gap_q;
        char_d  = char_q;
        ovr_d   = 1'b0;
        case (state_q)
            ST_IDLE, ST_COLLECT: begin
                ovr_d = both_sym || (one_sym && full);
                pat_d = app_pat;
                cnt_d = app_cnt;
                err_d = app_err;
                if (any_sym) begin
                    gap_d = '0;
                end else if (state_q == ST_COLLECT && gap_q != '1) begin
                    gap_d = gap_inc;
                end
                if (enter_pulse || commit_gap) begin
                    if (app_cnt == 3'd0 && !app_err) begin
                        char_d = ASCII_SPACE;
                    end else if (lut_hit && !app_err) begin
                        char_d = lut_ascii;
                    end else begin
                        char_d = ASCII_UNKNOWN;
                    end
                    pat_d   = '0;
                    cnt_d   = 3'd0;
                    err_d   = 1'b0;
                    gap_d   = '0;
                    state_d = ST_EMIT;
                end else if (any_sym) begin
                    state_d = ST_COLLECT;
                end
            end
            ST_EMIT: begin
                ovr_d = any_sym | enter_pulse;
                if (char_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            pat_q   <= '0;
            cnt_q   <= 3'd0;
            err_q   <= 1'b0;
            gap_q   <= '0;
            char_q  <= 8'h00;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            gap_q   <= gap_d;
            char_q  <= char_d;
            ovr_q   <= ovr_d;
        end
    end

    assign char_data  = char_q;
    assign char_valid = (state_q == ST_EMIT);
    assign sym_count  = cnt_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_morse_symbol_decoder.sv
// tb/tb_morse_symbol_decoder.sv - directed self-checking bench for morse_symbol_decoder
module tb_morse_symbol_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       dot_pulse = 1'b0;
    logic       dash_pulse = 1'b0;
    logic       enter_pulse = 1'b0;
    logic       char_ready = 1'b0;
    logic [7:0] char_data;
    logic       char_valid;
    logic [2:0] sym_count;
    logic       overrun;

    int total = 0;
    int bad   = 0;

    morse_symbol_decoder #(
        .MAX_SYMBOLS (5),
        .GAP_CYCLES  (20),
        .CNT_W       (27)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .dot_pulse   (dot_pulse),
        .dash_pulse  (dash_pulse),
        .enter_pulse (enter_pulse),
        .char_data   (char_data),
        .char_valid  (char_valid),
        .char_ready  (char_ready),
        .sym_count   (sym_count),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic d, input logic s, input logic e);
        dot_pulse   = d;
        dash_pulse  = s;
        enter_pulse = e;
        tick();
        dot_pulse   = 1'b0;
        dash_pulse  = 1'b0;
        enter_pulse = 1'b0;
    endtask

    task automatic accept();
        char_ready = 1'b1;
        tick();
        char_ready = 1'b0;
    endtask

    int n;
    int ovr_cnt;
    int held_bad;
    int seen_valid;

    initial begin
        #2;
        check("rst_data", char_data, 8'h00);
        check("rst_valid", char_valid, 0);
        check("rst_count", sym_count, 0);
        check("rst_ovr", overrun, 0);
        tick();
        rst = 1'b1;
        tick();

        // 1: A with ready held
        pulse(1, 0, 0);
        check("t1_cnt1", sym_count, 1);
        pulse(0, 1, 0);
        check("t1_cnt2", sym_count, 2);
        char_ready = 1'b1;
        pulse(0, 0, 1);
        check("t1_valid", char_valid, 1);
        check("t1_data", char_data, 8'h41);
        check("t1_cnt0", sym_count, 0);
        tick();
        char_ready = 1'b0;
        check("t1_done", char_valid, 0);
        check("t1_hold", char_data, 8'h41);

        // 2: five dashes then auto-commit
        for (int i = 0; i < 5; i++) pulse(0, 1, 0);
        check("t2_cnt5", sym_count, 5);
        n = 0;
        while (!char_valid && n < 40) begin
            tick();
            n++;
        end
        check("t2_latency", n, 20);
        check("t2_data", char_data, 8'h30);
        accept();
        check("t2_idle", char_valid, 0);

        // 3: six dots overflow, then empty enter
        for (int i = 0; i < 5; i++) pulse(1, 0, 0);
        check("t3_no_ovr", overrun, 0);
        pulse(1, 0, 0);
        check("t3_ovr", overrun, 1);
        check("t3_cnt", sym_count, 5);
        tick();
        check("t3_ovr_1cyc", overrun, 0);
        pulse(0, 0, 1);
        check("t3_data", char_data, 8'h3F);
        accept();
        pulse(0, 0, 1);
        check("t3_space_v", char_valid, 1);
        check("t3_space", char_data, 8'h20);
        accept();

        // 4: E held under backpressure with pulses dropped
        pulse(1, 0, 0);
        pulse(0, 0, 1);
        ovr_cnt  = 0;
        held_bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) pulse(1, 0, 0);
            else if (i == 6) pulse(0, 0, 1);
            else tick();
            if (overrun) ovr_cnt++;
            if (char_data !== 8'h45 || !char_valid) held_bad++;
        end
        check("t4_held", held_bad, 0);
        check("t4_ovr", ovr_cnt, 2);
        check("t4_cnt", sym_count, 0);
        accept();
        seen_valid = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (char_valid) seen_valid++;
        end
        check("t4_no_new", seen_valid, 0);

        // 5: simultaneous dot/dash poisons the character; dot+enter is one commit
        pulse(1, 1, 0);
        check("t5_ovr", overrun, 1);
        check("t5_cnt0", sym_count, 0);
        pulse(1, 0, 0);
        check("t5_cnt1", sym_count, 1);
        pulse(0, 0, 1);
        check("t5_unknown", char_data, 8'h3F);
        accept();
        pulse(1, 0, 1);
        check("t5_e_valid", char_valid, 1);
        check("t5_e", char_data, 8'h45);
        accept();

        // 6: async reset mid-COLLECT and mid-EMIT
        pulse(1, 0, 0);
        pulse(0, 1, 0);
        #2;
        rst = 1'b0;
        #1;
        check("t6_c_cnt", sym_count, 0);
        check("t6_c_data", char_data, 8'h00);
        tick();
        rst = 1'b1;
        seen_valid = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (char_valid) seen_valid++;
        end
        check("t6_c_none", seen_valid, 0);
        pulse(1, 0, 1);
        check("t6_e_valid", char_valid, 1);
        #2;
        rst = 1'b0;
        #1;
        check("t6_e_valid0", char_valid, 0);
        check("t6_e_data0", char_data, 8'h00);
        tick();
        rst = 1'b1;
        seen_valid = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (char_valid) seen_valid++;
        end
        check("t6_e_none", seen_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
